// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result channels of the pipelined adder.
// The producer/consumer side uses master; the adder itself uses slave.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained chunks, one per clock,
// with a single global advance enable giving full backpressure.
module pipelined_adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
endmodule

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic              adv;
    logic [STAGES:0]   vld_pipe;
    logic [WIDTH-1:0]  b_prep;
    logic              c_prep;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    assign adv           = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign vld_pipe[0]   = bus.in_valid;

    always_comb begin
        b_prep = bus.b;
        c_prep = 1'b0;
        case (bus.mode)
            2'b00:   c_prep = 1'b0;
            2'b01:   c_prep = 1'b1;
            2'b10: begin
                b_prep = ~bus.b;
                c_prep = 1'b1;
            end
            default: c_prep = bus.cin;
        endcase
    end

    // Bubbles travel with the data; nothing collapses, so order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe[STAGES:1] <= '0;
        else if (adv)
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * CHUNK;  // operand bits not yet added
        localparam int LO  = k * CHUNK;          // sum bits already finished

        // xa/xb shrink by one chunk per stage; the top bit stays the operand sign.
        logic [REM-1:0]      xa;
        logic [REM-1:0]      xb;
        logic [LO:0]         xs;   // {carry in, finished lower sum bits}
        logic [LO+CHUNK:0]   ns;
        logic [CHUNK-1:0]    ps;
        logic                co;

        pipelined_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .x  (xa[CHUNK-1:0]),
            .y  (xb[CHUNK-1:0]),
            .ci (xs[LO]),
            .s  (ps),
            .co (co)
        );

        if (k == 0) begin : g_cap
            assign xa = bus.a;
            assign xb = b_prep;
            assign xs = c_prep;
            assign ns = {co, ps};
        end else begin : g_reg
            localparam int PREM = REM + CHUNK;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xa <= '0;
                    xb <= '0;
                    xs <= '0;
                end else if (adv && vld_pipe[k-1]) begin
                    xa <= g_stage[k-1].xa[PREM-1:CHUNK];
                    xb <= g_stage[k-1].xb[PREM-1:CHUNK];
                    xs <= g_stage[k-1].ns;
                end
            end
            assign ns = {co, ps, xs[LO-1:0]};
        end

        if (k == STAGES - 1) begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (adv && vld_pipe[k]) begin
                    sum_q  <= ns[WIDTH-1:0];
                    cout_q <= ns[WIDTH];
                    ovf_q  <= (xa[CHUNK-1] == xb[CHUNK-1]) && (ps[CHUNK-1] != xa[CHUNK-1]);
                end
            end
        end
    end
endmodule
